// File: rtl/serial_shifter_pkg.sv
// Shared encodings for the serial shifter: op codes, FSM states and step sizes.
package serial_shifter_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_SLL  = 2'b00;
    localparam op_t OP_SRL  = 2'b01;
    localparam op_t OP_SRA  = 2'b10;
    localparam op_t OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int unsigned STEP_1 = 1;
    localparam int unsigned STEP_4 = 4;

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the serial shifter: shifts by STEP_1 or STEP_4
// with the fill bit selected by the operation.
module shift_step
    import serial_shifter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_i,
    input  op_t               op_i,
    input  logic              step4_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        unique case (op_i)
            OP_SLL: data_o = step4_i ? (data_i << STEP_4) : (data_i << STEP_1);
            OP_SRL: data_o = step4_i ? (data_i >> STEP_4) : (data_i >> STEP_1);
            OP_SRA: data_o = step4_i ? $unsigned($signed(data_i) >>> STEP_4)
                                     : $unsigned($signed(data_i) >>> STEP_1);
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle SLL/SRL/SRA unit with a start/done handshake, one bit per clock.
// Define SERIAL_SHIFTER_FAST_EN to take 4-bit steps while at least 4 remain.
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [DATA_W-1:0]  data_o
);

    state_e             state_q, state_d;
    op_t                op_q, op_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic               step4;
    logic [SHAMT_W-1:0] step_amt;
    logic [DATA_W-1:0]  stepped;
    logic               accept;

`ifdef SERIAL_SHIFTER_FAST_EN
    assign step4 = (count_q >= SHAMT_W'(STEP_4));
`else
    assign step4 = 1'b0;
`endif

    assign step_amt = step4 ? SHAMT_W'(STEP_4) : SHAMT_W'(STEP_1);

    shift_step #(
        .DATA_W (DATA_W)
    ) u_shift_step (
        .data_i  (data_q),
        .op_i    (op_q),
        .step4_i (step4),
        .data_o  (stepped)
    );

    // A new request may start in DONE, giving back-to-back results.
    assign accept = start_i && (state_q != SHIFT);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        data_d  = data_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    op_d    = op_i;
                    count_d = shamt_i;
                    data_d  = data_i;
                    state_d = (shamt_i == '0 || op_i == OP_PASS) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d  = stepped;
                count_d = count_q - step_amt;
                if (count_q == step_amt) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_SLL;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = (state_q == DONE);
    assign data_o = data_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: vector table plus handshake/reset sequences.
module tb_serial_shifter;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               start_i;
    logic [1:0]         op_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [DATA_W-1:0]  data_i;
    logic               busy_o;
    logic               done_o;
    logic [DATA_W-1:0]  data_o;

    serial_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .shamt_i (shamt_i),
        .data_i  (data_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int lat_of(input logic [1:0] op, input int n);
        if (n == 0 || op == 2'b11) return 1;
`ifdef SERIAL_SHIFTER_FAST_EN
        return n / 4 + n % 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    // Called at the first sample point after the accept edge; returns in the done cycle.
    task automatic wait_done(input int lat_exp, input string tag);
        int c = 1;
        int busy_cnt = 0;
        logic [31:0] exp;
        while (!done_o && c < 200) begin
            if (busy_o) busy_cnt++;
            @(posedge clk_i);
            #1;
            c++;
        end
        check({tag, " done seen"}, {31'b0, done_o}, 32'd1);
        check({tag, " latency"}, c, lat_exp);
        check({tag, " busy cycles"}, busy_cnt, lat_exp - 1);
        check({tag, " busy in done"}, {31'b0, busy_o}, 32'd0);
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check({tag, " data"}, data_o, exp);
        end
    endtask

    task automatic request(input logic [1:0] op, input logic [4:0] shamt,
                           input logic [31:0] data, input logic [31:0] exp);
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        shamt_i = shamt;
        data_i  = data;
        sb_q.push_back(exp);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    vec_t vecs[$];
    int   pulses;

    initial begin
        vecs.push_back('{2'b00, 5'd2,  32'h0000_0001, 32'h0000_0004});
        vecs.push_back('{2'b10, 5'd4,  32'h8000_0000, 32'hF800_0000});
        vecs.push_back('{2'b01, 5'd4,  32'h8000_0000, 32'h0800_0000});
        vecs.push_back('{2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{2'b10, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{2'b11, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{2'b00, 5'd9,  32'h0000_0001, 32'h0000_0200});
        vecs.push_back('{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001});
        vecs.push_back('{2'b00, 5'd31, 32'h0000_0003, 32'h8000_0000});
        vecs.push_back('{2'b10, 5'd5,  32'h7FFF_0000, 32'h03FF_F800});

        rst_i   = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        shamt_i = '0;
        data_i  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset busy", {31'b0, busy_o}, 32'd0);
        check("reset done", {31'b0, done_o}, 32'd0);
        check("reset data", data_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            request(vecs[i].op, vecs[i].shamt, vecs[i].data, vecs[i].exp);
            wait_done(lat_of(vecs[i].op, int'(vecs[i].shamt)), $sformatf("vec%0d", i));
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d done drops", i), {31'b0, done_o}, 32'd0);
            check($sformatf("vec%0d data held", i), data_o, vecs[i].exp);
        end

        // start_i held through SHIFT with junk, then a second request in the DONE cycle.
        request(2'b00, 5'd3, 32'h0000_0001, 32'h0000_0008);
        start_i = 1'b1;
        op_i    = 2'b10;
        shamt_i = 5'd5;
        data_i  = 32'hFFFF_0000;
        wait_done(lat_of(2'b00, 3), "hold first");
        op_i    = 2'b01;
        shamt_i = 5'd1;
        data_i  = 32'h0000_0100;
        sb_q.push_back(32'h0000_0080);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("b2b no idle busy", {31'b0, busy_o}, 32'd1);
        wait_done(lat_of(2'b01, 1), "b2b second");

        // Back-to-back pass-through: two consecutive done pulses.
        request(2'b11, 5'd3, 32'h1234_5678, 32'h1234_5678);
        check("pass1 done", {31'b0, done_o}, 32'd1);
        check("pass1 data", data_o, 32'h1234_5678);
        void'(sb_q.pop_front());
        request(2'b11, 5'd0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        wait_done(1, "pass2");

        // Asynchronous reset mid-shift aborts without a done pulse.
        request(2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
        repeat (5) @(posedge clk_i);
        #3;
        check("pre-abort busy", {31'b0, busy_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("abort busy", {31'b0, busy_o}, 32'd0);
        check("abort done", {31'b0, done_o}, 32'd0);
        check("abort data", data_o, 32'd0);
        sb_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) pulses++;
        end
        check("no done after abort", pulses, 32'd0);

        request(2'b01, 5'd2, 32'h0000_00F0, 32'h0000_003C);
        wait_done(lat_of(2'b01, 2), "after reset");
        check("scoreboard drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
